scarv_soc_bram_bridge: RTL
==========================

# scarv_soc_bram_bridge

Bridges the SoC request/response memory bus to one port of a dual-port byte-write BRAM. It acts as the bus responder and the BRAM port driver, and sits between the interconnect and each on-chip RAM/ROM instance. It issues one BRAM access per accepted request and returns each response exactly once. It holds a response while the requester stalls, and flags out-of-range or illegal-write requests as errors without touching the BRAM.

## Interface
- `DEPTH`, 1024: BRAM size in bytes; power of two, at least 8.
- `WRITE_EN`, 1: 0 makes the target read-only; writes then return an error.
- `LW`, $clog2(DEPTH): local; BRAM byte-address width.
- `g_clk` in 1: clock, all state on rising edge.
- `g_resetn` in 1: asynchronous active-low reset.
- `mem_req` in 1: request valid.
- `mem_gnt` out 1: request accepted this cycle when `mem_req && mem_gnt`.
- `mem_wen` in 1: 1 = write, 0 = read.
- `mem_strb` in 4: byte-lane write strobes.
- `mem_addr` in 32: byte address; bits [1:0] ignored.
- `mem_wdata` in 32: write data.
- `mem_recv` out 1: response valid.
- `mem_ack` in 1: response consumed when `mem_recv && mem_ack`.
- `mem_error` out 1: response is an error; valid with `mem_recv`.
- `mem_rdata` out 32: read data; valid with `mem_recv`.
- `bram_en` out 1: BRAM port enable.
- `bram_wen` out 4: BRAM byte write enables.
- `bram_addr` out LW: BRAM byte address; the BRAM uses bits [LW-1:2].
- `bram_wdata` out 32: BRAM write data.
- `bram_rdata` in 32: BRAM read data, valid one cycle after `bram_en`.

## Operation
- State: `rdy` (out of reset), `p1` (access issued last cycle), `p1_err`, `p1_wr`, `h_valid`, `h_err`, `h_data[31:0]`.
- `rdy` is cleared by reset and set on the first `g_clk` edge after release.
- `mem_gnt = rdy && !h_valid && !(p1 && !mem_ack)`. This path is combinational from `mem_ack`.
- `err = (mem_addr[31:LW] != 0) || (mem_wen && !WRITE_EN)`.
- `bram_en = mem_req && mem_gnt && !err`.
- `bram_wen = (bram_en && mem_wen) ? mem_strb : 0`.
- `bram_addr = mem_addr[LW-1:0]`; `bram_wdata = mem_wdata` (pass-through).
- On acceptance: `p1 <= 1`, `p1_err <= err`, `p1_wr <= mem_wen`. With no acceptance, `p1 <= 0`.
- Response source: the hold register if `h_valid`, else the p1 stage.
  - `mem_recv = h_valid || p1`.
  - `mem_error = h_valid ? h_err : p1_err`.
  - `mem_rdata = h_valid ? h_data : ((p1_err || p1_wr) ? 0 : bram_rdata)`.
- `p1 && !h_valid && !mem_ack`: capture `h_data` (the p1 `mem_rdata` value) and `h_err <= p1_err`, then set `h_valid`.
- `h_valid && mem_ack`: clear `h_valid`.
- No acceptance is possible while `h_valid`, so at most one response is outstanding besides the one being presented.
- An all-zero `mem_strb` write is legal: the BRAM is enabled, no bytes change, and the response has `error=0`.
- An error request never asserts `bram_en`. Its response has `mem_error=1`, `mem_rdata=0`.

## Timing
- Reset values: `mem_gnt=0`, `mem_recv=0`, `mem_error=0`, `mem_rdata=0`, `bram_en=0`, `bram_wen=0`; all state is clear.
- `mem_gnt` rises in the first cycle after the first post-release edge.
- Latency is 1 cycle: a request accepted in cycle N has `mem_recv=1` in cycle N+1.
- Throughput is 1 request per cycle while `mem_ack` is high every response cycle.
- After a stall, the held response is presented; `mem_gnt` stays 0 until the cycle after the ack.
- Responses return in request order, with no drop and no duplication.
- Reset mid-operation: the in-flight and held responses are discarded. BRAM contents are unaffected; a write whose `bram_en` cycle completed is retained.

## Test plan
- Reset release with `mem_req=1`: `mem_gnt=0` until the first edge after release, then 1. `bram_en` is never high during reset.
- Write 0xDEADBEEF with strobe 0xF to addr 0x10, then read 0x10 with `mem_ack` held high: read response in the cycle after acceptance, `rdata=0xDEADBEEF`, `error=0`.
- Write 0x000000AA with strobe 0x1 to addr 0x10 (holding 0xDEADBEEF), then read 0x10: returns 0xDEADBEAA.
- Back-to-back reads of 0x0, 0x4, 0x8 with `mem_ack=0` for 3 cycles on the first response: the first response is held stable, `mem_gnt=0` while held, and all three return in order with correct data after ack.
- Read at addr `DEPTH` (0x400 with defaults): `bram_en=0`, response `error=1`, `rdata=0`. `WRITE_EN=0` write to 0x0: `error=1`, and a subsequent read of 0x0 returns the original contents.
- Assert `g_resetn=0` while a response is held: `mem_recv` drops immediately. After release, a read of a previously written address returns the written data.

Source files
------------

// File: rtl/scarv_soc_bram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module : scarv_soc_bram_bridge_if
// Brief  : SoC request/response memory bus bundle (requester = master).
// Rev    : 1.0 - initial release
// ============================================================================
interface scarv_soc_bram_bridge_if;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_recv;
  logic        mem_ack;
  logic        mem_error;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
    input  mem_gnt, mem_recv, mem_error, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
    output mem_gnt, mem_recv, mem_error, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/scarv_soc_bram_bridge.sv
`default_nettype none
// ============================================================================
// Module : scarv_soc_bram_bridge
// Brief  : Memory bus responder driving one port of a byte-write BRAM.
// Rev    : 1.0 - initial release
// ============================================================================
module scarv_soc_bram_bridge #(
  parameter  int DEPTH    = 1024,
  parameter  bit WRITE_EN = 1'b1,
  localparam int LW       = $clog2(DEPTH)
) (
  input  logic                   g_clk,
  input  logic                   g_resetn,
  scarv_soc_bram_bridge_if.slave mem,
  output logic                   bram_en,
  output logic [3:0]             bram_wen,
  output logic [LW-1:0]          bram_addr,
  output logic [31:0]            bram_wdata,
  input  logic [31:0]            bram_rdata
);

  logic        r_rdy;
  logic        r_p1;
  logic        r_p1_err;
  logic        r_p1_wr;
  logic        r_h_valid;
  logic        r_h_err;
  logic [31:0] r_h_data;

  logic        w_gnt;
  logic        w_err;
  logic        w_acc;
  logic [31:0] w_p1_rdata;

  // A new request is only taken if the previous response leaves this cycle.
  assign w_gnt = r_rdy && !r_h_valid && !(r_p1 && !mem.mem_ack);
  assign w_err = (mem.mem_addr[31:LW] != '0) || (mem.mem_wen && !WRITE_EN);
  assign w_acc = mem.mem_req && w_gnt;

  assign bram_en    = w_acc && !w_err;
  assign bram_wen   = (bram_en && mem.mem_wen) ? mem.mem_strb : 4'h0;
  assign bram_addr  = mem.mem_addr[LW-1:0];
  assign bram_wdata = mem.mem_wdata;

  assign w_p1_rdata = (r_p1 && !r_p1_err && !r_p1_wr) ? bram_rdata : 32'h0;

  assign mem.mem_gnt   = w_gnt;
  assign mem.mem_recv  = r_h_valid || r_p1;
  assign mem.mem_error = r_h_valid ? r_h_err  : (r_p1 && r_p1_err);
  assign mem.mem_rdata = r_h_valid ? r_h_data : w_p1_rdata;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_rdy     <= 1'b0;
      r_p1      <= 1'b0;
      r_p1_err  <= 1'b0;
      r_p1_wr   <= 1'b0;
      r_h_valid <= 1'b0;
      r_h_err   <= 1'b0;
      r_h_data  <= 32'h0;
    end else begin
      r_rdy <= 1'b1;
      r_p1  <= w_acc;
      if (w_acc) begin
        r_p1_err <= w_err;
        r_p1_wr  <= mem.mem_wen;
      end
      // BRAM read data is only valid for one cycle, so a stalled response is parked.
      if (r_p1 && !r_h_valid && !mem.mem_ack) begin
        r_h_valid <= 1'b1;
        r_h_err   <= r_p1_err;
        r_h_data  <= w_p1_rdata;
      end else if (r_h_valid && mem.mem_ack) begin
        r_h_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
